// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32I sequencing FSM: states, opcodes,
// datapath select codes and the opcode-class decode.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned COUNT_W  = 32;

  localparam logic [STATE_W-1:0] FETCH      = 4'd0;
  localparam logic [STATE_W-1:0] FETCH_WAIT = 4'd1;
  localparam logic [STATE_W-1:0] DECODE     = 4'd2;
  localparam logic [STATE_W-1:0] EXECUTE    = 4'd3;
  localparam logic [STATE_W-1:0] MEM_ADDR   = 4'd4;
  localparam logic [STATE_W-1:0] MEM_READ   = 4'd5;
  localparam logic [STATE_W-1:0] MEM_WRITE  = 4'd6;
  localparam logic [STATE_W-1:0] WRITEBACK  = 4'd7;
  localparam logic [STATE_W-1:0] BRANCH     = 4'd8;
  localparam logic [STATE_W-1:0] JUMP       = 4'd9;
  localparam logic [STATE_W-1:0] HALT       = 4'd10;

  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_FENCE  = 7'b0001111;
  localparam logic [OPCODE_W-1:0] OP_SYSTEM = 7'b1110011;

  localparam logic [SEL_W-1:0] RES_ALU   = 2'd0;
  localparam logic [SEL_W-1:0] RES_MEM   = 2'd1;
  localparam logic [SEL_W-1:0] RES_PC4   = 2'd2;
  localparam logic [SEL_W-1:0] A_RS1     = 2'd0;
  localparam logic [SEL_W-1:0] A_PC      = 2'd1;
  localparam logic [SEL_W-1:0] A_ZERO    = 2'd2;
  localparam logic [SEL_W-1:0] B_RS2     = 2'd0;
  localparam logic [SEL_W-1:0] B_IMM     = 2'd1;
  localparam logic [SEL_W-1:0] B_FOUR    = 2'd2;
  localparam logic [SEL_W-1:0] ALU_ADD   = 2'd0;
  localparam logic [SEL_W-1:0] ALU_FUNCT = 2'd1;
  localparam logic [SEL_W-1:0] ALU_CMP   = 2'd2;

  typedef enum logic [3:0] {
    CL_ALU_R, CL_ALU_I, CL_LUI, CL_AUIPC, CL_LOAD, CL_STORE,
    CL_BRANCH, CL_JAL, CL_JALR, CL_FENCE, CL_SYSTEM, CL_ILLEGAL
  } op_class_e;

  function automatic op_class_e classify(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_R:      return CL_ALU_R;
      OP_I:      return CL_ALU_I;
      OP_LUI:    return CL_LUI;
      OP_AUIPC:  return CL_AUIPC;
      OP_LOAD:   return CL_LOAD;
      OP_STORE:  return CL_STORE;
      OP_BRANCH: return CL_BRANCH;
      OP_JAL:    return CL_JAL;
      OP_JALR:   return CL_JALR;
      OP_FENCE:  return CL_FENCE;
      OP_SYSTEM: return CL_SYSTEM;
      default:   return CL_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath strobe/select bundle.
interface multicycle_control_if;
  import mc_ctrl_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic                branch_taken;
  logic                pc_write_en;
  logic                pc_src_sel;
  logic                ir_write_en;
  logic                mem_addr_sel;
  logic                memory_write_en;
  logic                register_write_en;
  logic [SEL_W-1:0]    result_sel;
  logic [SEL_W-1:0]    alu_a_sel;
  logic [SEL_W-1:0]    alu_b_sel;
  logic [SEL_W-1:0]    alu_op;
  logic                halted;
  logic                illegal_instr;
  logic                instr_retired;
  logic [COUNT_W-1:0]  retired_count;

  modport master (
    input  opcode, branch_taken,
    output pc_write_en, pc_src_sel, ir_write_en, mem_addr_sel, memory_write_en,
           register_write_en, result_sel, alu_a_sel, alu_b_sel, alu_op,
           halted, illegal_instr, instr_retired, retired_count
  );

  modport slave (
    output opcode, branch_taken,
    input  pc_write_en, pc_src_sel, ir_write_en, mem_addr_sel, memory_write_en,
           register_write_en, result_sel, alu_a_sel, alu_b_sel, alu_op,
           halted, illegal_instr, instr_retired, retired_count
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32I sequencing FSM: Moore strobes per state, memory wait
// counter, sticky halt/illegal flags and a retired-instruction counter.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  localparam int unsigned WAIT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_LATENCY - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  op_class_e          class_q, class_d, dec_class;
  logic               illegal_q, illegal_d;
  logic [COUNT_W-1:0] count_q;
  logic               retire;

  assign dec_class = classify(bus.opcode);

  // State, wait counter, latched opcode class and sticky flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      class_q   <= CL_ILLEGAL;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      class_q   <= class_d;
      illegal_q <= illegal_d;
      if (retire) count_q <= count_q + COUNT_W'(1);
    end
  end

  // Next state and per-state strobes
  always_comb begin
    state_d               = state_q;
    wait_d                = wait_q;
    class_d               = class_q;
    illegal_d             = illegal_q;
    retire                = 1'b0;
    bus.pc_src_sel        = 1'b0;
    bus.ir_write_en       = 1'b0;
    bus.mem_addr_sel      = 1'b0;
    bus.memory_write_en   = 1'b0;
    bus.register_write_en = 1'b0;
    bus.result_sel        = RES_ALU;
    bus.alu_a_sel         = A_RS1;
    bus.alu_b_sel         = B_RS2;
    bus.alu_op            = ALU_ADD;

    case (state_q)
      FETCH: begin
        state_d = FETCH_WAIT;
        wait_d  = WAIT_LOAD;
      end
      FETCH_WAIT: begin
        if (wait_q == '0) begin
          bus.ir_write_en = 1'b1;
          state_d         = DECODE;
        end else begin
          wait_d = WAIT_W'(wait_q - 1'b1);
        end
      end
      DECODE: begin
        // Branch/JAL target PC+imm is formed here and held in the ALU register
        bus.alu_a_sel = A_PC;
        bus.alu_b_sel = B_IMM;
        class_d       = dec_class;
        case (dec_class)
          CL_ALU_R, CL_ALU_I, CL_LUI, CL_AUIPC, CL_JALR: state_d = EXECUTE;
          CL_LOAD, CL_STORE:                             state_d = MEM_ADDR;
          CL_BRANCH:                                     state_d = BRANCH;
          CL_JAL:                                        state_d = JUMP;
          CL_FENCE: begin
            retire  = 1'b1;
            state_d = FETCH;
          end
          CL_SYSTEM: state_d = HALT;
          default: begin
            illegal_d = 1'b1;
            state_d   = HALT;
          end
        endcase
      end
      EXECUTE: begin
        case (class_q)
          CL_ALU_R: bus.alu_op = ALU_FUNCT;
          CL_ALU_I: begin
            bus.alu_b_sel = B_IMM;
            bus.alu_op    = ALU_FUNCT;
          end
          CL_LUI: begin
            bus.alu_a_sel = A_ZERO;
            bus.alu_b_sel = B_IMM;
          end
          CL_AUIPC: begin
            bus.alu_a_sel = A_PC;
            bus.alu_b_sel = B_IMM;
          end
          default: bus.alu_b_sel = B_IMM;
        endcase
        state_d = (class_q == CL_JALR) ? JUMP : WRITEBACK;
      end
      MEM_ADDR: begin
        bus.alu_b_sel = B_IMM;
        wait_d        = WAIT_LOAD;
        state_d       = (class_q == CL_LOAD) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        bus.mem_addr_sel = 1'b1;
        if (wait_q == '0) state_d = WRITEBACK;
        else              wait_d  = WAIT_W'(wait_q - 1'b1);
      end
      MEM_WRITE: begin
        bus.mem_addr_sel    = 1'b1;
        bus.memory_write_en = 1'b1;
        retire              = 1'b1;
        state_d             = FETCH;
      end
      WRITEBACK: begin
        bus.register_write_en = 1'b1;
        bus.result_sel        = (class_q == CL_LOAD) ? RES_MEM : RES_ALU;
        retire                = 1'b1;
        state_d               = FETCH;
      end
      BRANCH: begin
        bus.alu_op     = ALU_CMP;
        bus.pc_src_sel = bus.branch_taken;
        retire         = 1'b1;
        state_d        = FETCH;
      end
      JUMP: begin
        bus.register_write_en = 1'b1;
        bus.result_sel        = RES_PC4;
        bus.pc_src_sel        = 1'b1;
        retire                = 1'b1;
        state_d               = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  assign bus.pc_write_en   = retire;
  assign bus.instr_retired = retire;
  assign bus.halted        = (state_q == HALT);
  assign bus.illegal_instr = illegal_q;
  assign bus.retired_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control at MEM_LATENCY = 1, 2 and 4.
module tb_multicycle_control;

  logic clk;
  logic r1, r2, r4;
  int   n_cmp = 0;
  int   n_err = 0;

  multicycle_control_if if1 ();
  multicycle_control_if if2 ();
  multicycle_control_if if4 ();

  multicycle_control #(.MEM_LATENCY(1)) u1 (.clk(clk), .reset(r1), .bus(if1));
  multicycle_control #(.MEM_LATENCY(2)) u2 (.clk(clk), .reset(r2), .bus(if2));
  multicycle_control #(.MEM_LATENCY(4)) u4 (.clk(clk), .reset(r4), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // advance to the next cycle and sample mid-low-phase
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int          first_reg, first_pc, pulses;
    logic [15:0] m_ir, m_addr, m_reg, m_pc, m_mw, m_any;
    logic [1:0]  d_a, d_b, d_op, e_a, e_b, e_op, rsel8;
    logic        p4_we, p4_src, p4_src_nt, p8_we, p8_src, h3, h4, i3, i4;
    int          halt_first;

    r1 = 1'b1; r2 = 1'b1; r4 = 1'b1;
    if1.opcode = 7'b0110011; if1.branch_taken = 1'b0;
    if2.opcode = 7'b0000011; if2.branch_taken = 1'b0;
    if4.opcode = 7'b0000011; if4.branch_taken = 1'b0;
    cyc(); cyc();

    // reset state
    chk("rst_pc_we", 32'(if1.pc_write_en), 0);
    chk("rst_ir_we", 32'(if1.ir_write_en), 0);
    chk("rst_sels", {26'd0, if1.alu_a_sel, if1.alu_b_sel, if1.alu_op}, 0);
    chk("rst_halted", 32'(if1.halted), 0);
    chk("rst_illegal", 32'(if1.illegal_instr), 0);
    chk("rst_count", if1.retired_count, 0);

    // R-type stream, L=1
    @(negedge clk); r1 = 1'b0; #1;
    first_reg = 0; first_pc = 0; pulses = 0;
    for (int c = 1; c <= 50; c++) begin
      if (first_reg == 0 && if1.register_write_en) first_reg = c;
      if (first_pc == 0 && if1.pc_write_en) first_pc = c;
      if (if1.instr_retired) pulses++;
      if (c == 3) begin d_a = if1.alu_a_sel; d_b = if1.alu_b_sel; d_op = if1.alu_op; end
      if (c == 4) begin e_a = if1.alu_a_sel; e_b = if1.alu_b_sel; e_op = if1.alu_op; end
      cyc();
    end
    chk("r_first_reg_we", 32'(first_reg), 5);
    chk("r_first_pc_we", 32'(first_pc), 5);
    chk("r_decode_sels", {26'd0, d_a, d_b, d_op}, {26'd0, 2'd1, 2'd1, 2'd0});
    chk("r_exec_sels", {26'd0, e_a, e_b, e_op}, {26'd0, 2'd0, 2'd0, 2'd1});
    chk("r_pulses", 32'(pulses), 10);
    chk("r_count50", if1.retired_count, 10);

    // load, L=2
    @(negedge clk); r2 = 1'b0; #1;
    m_ir = '0; m_addr = '0; m_reg = '0; rsel8 = 2'd3;
    for (int c = 1; c <= 8; c++) begin
      m_ir[c]   = if2.ir_write_en;
      m_addr[c] = if2.mem_addr_sel;
      m_reg[c]  = if2.register_write_en;
      if (c == 8) rsel8 = if2.result_sel;
      cyc();
    end
    chk("ld_ir_mask", 32'(m_ir), 32'h0008);
    chk("ld_addr_mask", 32'(m_addr), 32'h00C0);
    chk("ld_reg_mask", 32'(m_reg), 32'h0100);
    chk("ld_result_sel", 32'(rsel8), 1);
    chk("ld_count", if2.retired_count, 1);

    // branch taken then not taken, L=1
    r1 = 1'b1; if1.opcode = 7'b1100011; if1.branch_taken = 1'b1;
    @(negedge clk); r1 = 1'b0; #1;
    m_reg = '0;
    for (int c = 1; c <= 8; c++) begin
      m_reg[c] = if1.register_write_en;
      if (c == 4) begin
        p4_we = if1.pc_write_en; p4_src = if1.pc_src_sel;
        if1.branch_taken = 1'b0; #1;
        p4_src_nt = if1.pc_src_sel;
      end
      if (c == 8) begin p8_we = if1.pc_write_en; p8_src = if1.pc_src_sel; end
      cyc();
    end
    chk("br_taken", {30'd0, p4_we, p4_src}, 32'b11);
    chk("br_comb_follow", 32'(p4_src_nt), 0);
    chk("br_not_taken", {30'd0, p8_we, p8_src}, 32'b10);
    chk("br_no_reg_we", 32'(m_reg), 0);
    chk("br_count", if1.retired_count, 2);

    // store, L=1
    r1 = 1'b1; if1.opcode = 7'b0100011;
    @(negedge clk); r1 = 1'b0; #1;
    m_mw = '0; m_addr = '0; m_reg = '0; m_pc = '0;
    for (int c = 1; c <= 8; c++) begin
      m_mw[c]   = if1.memory_write_en;
      m_addr[c] = if1.mem_addr_sel & if1.memory_write_en;
      m_reg[c]  = if1.register_write_en;
      m_pc[c]   = if1.pc_write_en;
      cyc();
    end
    chk("st_mw_mask", 32'(m_mw), 32'h0020);
    chk("st_addr_with_mw", 32'(m_addr), 32'h0020);
    chk("st_no_reg_we", 32'(m_reg), 0);
    chk("st_pc_mask", 32'(m_pc), 32'h0020);

    // ECALL halts, L=1
    r1 = 1'b1; if1.opcode = 7'b1110011;
    @(negedge clk); r1 = 1'b0; #1;
    halt_first = 0; m_any = '0; pulses = 0;
    for (int c = 1; c <= 104; c++) begin
      if (halt_first == 0 && if1.halted) halt_first = c;
      if (c >= 4 && (if1.pc_write_en | if1.register_write_en | if1.memory_write_en |
                     if1.ir_write_en | if1.instr_retired)) pulses++;
      cyc();
    end
    chk("sys_halt_cycle", 32'(halt_first), 4);
    chk("sys_no_strobes", 32'(pulses), 0);
    chk("sys_count", if1.retired_count, 0);
    chk("sys_not_illegal", 32'(if1.illegal_instr), 0);
    chk("sys_still_halted", 32'(if1.halted), 1);

    // illegal opcode, L=1
    r1 = 1'b1; if1.opcode = 7'b1111111;
    @(negedge clk); r1 = 1'b0; #1;
    h3 = 1'b0; i3 = 1'b0; h4 = 1'b0; i4 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 3) begin h3 = if1.halted; i3 = if1.illegal_instr; end
      if (c == 4) begin h4 = if1.halted; i4 = if1.illegal_instr; end
      cyc();
    end
    chk("ill_cycle3", {30'd0, h3, i3}, 0);
    chk("ill_cycle4", {30'd0, h4, i4}, 32'b11);
    chk("ill_sticky", {30'd0, if1.halted, if1.illegal_instr}, 32'b11);

    // async reset in MEM_READ, L=4 (MEM_READ spans cycles 8..11)
    @(negedge clk); r4 = 1'b0; #1;
    for (int c = 1; c < 9; c++) cyc();
    chk("l4_in_mem_read", 32'(if4.mem_addr_sel), 1);
    #1; r4 = 1'b1; #1;
    chk("l4_async_outs", {22'd0, if4.pc_write_en, if4.ir_write_en, if4.mem_addr_sel,
                          if4.memory_write_en, if4.register_write_en, if4.halted,
                          if4.illegal_instr, if4.instr_retired, if4.alu_a_sel == 2'd0,
                          if4.alu_b_sel == 2'd0},
        32'b11);
    chk("l4_async_count", if4.retired_count, 0);
    @(negedge clk); r4 = 1'b0; #1;
    m_ir = '0;
    for (int c = 1; c <= 6; c++) begin
      m_ir[c] = if4.ir_write_en;
      cyc();
    end
    chk("l4_ir_mask", 32'(m_ir), 32'h0020);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
